// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side and APB-side signals for apb_req_arbiter.
// master: the arbiter's view; slave: the view of the requesters plus the APB peripheral.
interface apb_req_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        done;
   logic [DATA_W-1:0]         rdata;
   logic                      err;
   logic                      psel;
   logic                      penable;
   logic                      pwrite;
   logic [ADDR_W-1:0]         paddr;
   logic [DATA_W-1:0]         pwdata;
   logic [DATA_W-1:0]         prdata;
   logic                      pready;
   logic                      pslverr;

   modport master (
      input  req, req_write, req_addr, req_wdata, prdata, pready, pslverr,
      output gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output req, req_write, req_addr, req_wdata, prdata, pready, pslverr,
      input  gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Define APB_REQ_ARBITER_TIMEOUT_EN to abort ACCESS phases stalled for TIMEOUT_CYC cycles.
module apb_req_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                reset,
   apb_req_arbiter_if.master   bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW    = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [PTR_W-1:0]    ptr_r, ptr_nxt_s, win_r, win_nxt_s, pick_s;
   logic                any_s, timeout_s;
   logic [NUM_REQ-1:0]  gnt_r, gnt_nxt_s, done_r, done_nxt_s;
   logic                psel_r, psel_nxt_s, penable_r, penable_nxt_s;
   logic                pwrite_r, pwrite_nxt_s, err_r, err_nxt_s;
   logic [ADDR_W-1:0]   paddr_r, paddr_nxt_s;
   logic [DATA_W-1:0]   pwdata_r, pwdata_nxt_s, rdata_r, rdata_nxt_s;
   logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
   logic [DATA_W-1:0]   wdata_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_a[g] = bus.req_wdata[g*DATA_W +: DATA_W];
   end

   // Round-robin pick: scan downward so the candidate closest to ptr_r is assigned last.
   always_comb begin
      logic [CW-1:0] sum_v;
      logic [CW-1:0] cand_v;
      sum_v  = '0;
      cand_v = '0;
      any_s  = 1'b0;
      pick_s = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum_v  = {1'b0, ptr_r} + CW'(k);
         cand_v = (sum_v >= CW'(NUM_REQ)) ? (sum_v - CW'(NUM_REQ)) : sum_v;
         any_s  = any_s | bus.req[cand_v[PTR_W-1:0]];
         pick_s = bus.req[cand_v[PTR_W-1:0]] ? cand_v[PTR_W-1:0] : pick_s;
      end
   end

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [TCNT_W-1:0] tcnt_r;

   // Stall counter for the current ACCESS phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt_r <= '0;
      end else if (state_r == ST_SETUP) begin
         tcnt_r <= '0;
      end else if ((state_r == ST_ACCESS) && !bus.pready) begin
         tcnt_r <= tcnt_r + TCNT_W'(1);
      end else begin
         tcnt_r <= tcnt_r;
      end
   end

   assign timeout_s = (state_r == ST_ACCESS) && !bus.pready &&
                      (tcnt_r == TCNT_W'(TIMEOUT_CYC - 1));
`else
   logic [31:0] timeout_unused_s;
   assign timeout_unused_s = 32'(TIMEOUT_CYC);
   assign timeout_s        = 1'b0;
`endif

   // Next state and next values of every registered output.
   always_comb begin
      state_nxt_s   = state_r;
      ptr_nxt_s     = ptr_r;
      win_nxt_s     = win_r;
      gnt_nxt_s     = gnt_r;
      done_nxt_s    = '0;
      psel_nxt_s    = psel_r;
      penable_nxt_s = penable_r;
      pwrite_nxt_s  = pwrite_r;
      paddr_nxt_s   = paddr_r;
      pwdata_nxt_s  = pwdata_r;
      rdata_nxt_s   = rdata_r;
      err_nxt_s     = err_r;
      case (state_r)
         ST_IDLE: begin
            psel_nxt_s    = 1'b0;
            penable_nxt_s = 1'b0;
            gnt_nxt_s     = '0;
            if (any_s) begin
               state_nxt_s         = ST_SETUP;
               win_nxt_s           = pick_s;
               psel_nxt_s          = 1'b1;
               gnt_nxt_s[pick_s]   = 1'b1;
               pwrite_nxt_s        = bus.req_write[pick_s];
               paddr_nxt_s         = addr_a[pick_s];
               pwdata_nxt_s        = wdata_a[pick_s];
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_nxt_s   = ST_ACCESS;
            penable_nxt_s = 1'b1;
         end
         ST_ACCESS: begin
            if (bus.pready || timeout_s) begin
               state_nxt_s       = ST_IDLE;
               psel_nxt_s        = 1'b0;
               penable_nxt_s     = 1'b0;
               gnt_nxt_s         = '0;
               done_nxt_s[win_r] = 1'b1;
               ptr_nxt_s         = (win_r == PTR_W'(NUM_REQ - 1)) ? '0 : (win_r + PTR_W'(1));
               // A timeout only reaches here with pready low, so it always reports an error.
               err_nxt_s         = bus.pready ? bus.pslverr : 1'b1;
               rdata_nxt_s       = (bus.pready && !pwrite_r) ? bus.prdata : rdata_r;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            psel_nxt_s    = 1'b0;
            penable_nxt_s = 1'b0;
            gnt_nxt_s     = '0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Registered outputs, pointer and latched winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r     <= '0;
         win_r     <= '0;
         gnt_r     <= '0;
         done_r    <= '0;
         psel_r    <= 1'b0;
         penable_r <= 1'b0;
         pwrite_r  <= 1'b0;
         paddr_r   <= '0;
         pwdata_r  <= '0;
         rdata_r   <= '0;
         err_r     <= 1'b0;
      end else begin
         ptr_r     <= ptr_nxt_s;
         win_r     <= win_nxt_s;
         gnt_r     <= gnt_nxt_s;
         done_r    <= done_nxt_s;
         psel_r    <= psel_nxt_s;
         penable_r <= penable_nxt_s;
         pwrite_r  <= pwrite_nxt_s;
         paddr_r   <= paddr_nxt_s;
         pwdata_r  <= pwdata_nxt_s;
         rdata_r   <= rdata_nxt_s;
         err_r     <= err_nxt_s;
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.done    = done_r;
   assign bus.rdata   = rdata_r;
   assign bus.err     = err_r;
   assign bus.psel    = psel_r;
   assign bus.penable = penable_r;
   assign bus.pwrite  = pwrite_r;
   assign bus.paddr   = paddr_r;
   assign bus.pwdata  = pwdata_r;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: per-cycle vector table plus hand sequences
// for round-robin order, reset mid-transfer and stalled ACCESS (APB_REQ_ARBITER_TIMEOUT_EN aware).
module tb_apb_req_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 32;
   localparam int TIMEOUT_CYC = 16;

   localparam logic [31:0] W0 = 32'hC0C0C0C0;
   localparam logic [31:0] W1 = 32'h11111111;
   localparam logic [31:0] W2 = 32'hDEADBEEF;
   localparam logic [31:0] W3 = 32'h33333333;
   localparam logic [31:0] A5 = 32'hA5A5A5A5;
   localparam logic [31:0] RD = 32'h5A5A0001;

   logic clk = 1'b0;
   logic reset;

   apb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_req_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic        pready;
      logic        pslverr;
      logic [31:0] prdata;
      logic        e_psel;
      logic        e_pen;
      logic [3:0]  e_gnt;
      logic [3:0]  e_done;
      logic        e_err;
      logic [31:0] e_rdata;
      logic [7:0]  e_paddr;
      logic        e_pwrite;
      logic [31:0] e_pwdata;
   } vec_t;

   localparam int NV = 27;
   vec_t vt [NV];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic pready,
                               input logic pslverr, input logic [31:0] prdata,
                               input logic psel, input logic pen, input logic [3:0] gnt,
                               input logic [3:0] done, input logic err, input logic [31:0] rdata,
                               input logic [7:0] paddr, input logic pwrite, input logic [31:0] pwdata);
      vec_t v;
      v.rst = rst; v.req = req; v.pready = pready; v.pslverr = pslverr; v.prdata = prdata;
      v.e_psel = psel; v.e_pen = pen; v.e_gnt = gnt; v.e_done = done; v.e_err = err;
      v.e_rdata = rdata; v.e_paddr = paddr; v.e_pwrite = pwrite; v.e_pwdata = pwdata;
      return v;
   endfunction

   // Waits for a done pulse; reports the grant seen in SETUP and the number of ACCESS cycles.
   task automatic wait_done(input int budget, output logic [3:0] d, output logic [3:0] g, output int acc);
      d = 4'b0000; g = 4'b0000; acc = 0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #1;
         if (bus.psel && !bus.penable) g = bus.gnt;
         if (bus.penable) acc++;
         if (bus.done != 4'b0000) begin
            d = bus.done;
            break;
         end
      end
   endtask

   initial begin
      logic [3:0] d;
      logic [3:0] g;
      int         acc;
      int         hi_cnt;
      int         d_cnt;
      bit         seen;

      reset         = 1'b1;
      bus.req       = 4'b0000;
      bus.req_write = 4'b0110;
      bus.req_addr  = {8'h30, 8'h10, 8'h20, 8'h04};
      bus.req_wdata = {W3, W2, W1, W0};
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      bus.prdata    = 32'h0;

      vt[0]  = mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         8'h00, 1'b0, 32'h0);
      vt[1]  = mk(1'b0, 4'b0100, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 32'h0,         8'h10, 1'b1, W2);
      vt[2]  = mk(1'b0, 4'b0100, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 32'h0,         8'h10, 1'b1, W2);
      vt[3]  = mk(1'b0, 4'b0100, 1'b1, 1'b0, 32'hFFFFFFFF,  1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 32'h0,         8'h10, 1'b1, W2);
      vt[4]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,         8'h10, 1'b1, W2);
      vt[5]  = mk(1'b0, 4'b0001, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0,         8'h04, 1'b0, W0);
      for (int i = 6; i <= 9; i++)
         vt[i] = mk(1'b0, 4'b0001, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 32'h0,         8'h04, 1'b0, W0);
      vt[10] = mk(1'b0, 4'b0001, 1'b1, 1'b0, A5,            1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, A5,            8'h04, 1'b0, W0);
      vt[11] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, A5,            8'h04, 1'b0, W0);
      vt[12] = mk(1'b0, 4'b0010, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, A5,            8'h20, 1'b1, W1);
      vt[13] = mk(1'b0, 4'b0010, 1'b1, 1'b1, 32'h0,         1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, A5,            8'h20, 1'b1, W1);
      vt[14] = mk(1'b0, 4'b0010, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, A5,            8'h20, 1'b1, W1);
      vt[15] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, A5,            8'h20, 1'b1, W1);
      vt[16] = mk(1'b0, 4'b0100, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, A5,            8'h10, 1'b1, W2);
      vt[17] = mk(1'b0, 4'b0100, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1, A5,            8'h10, 1'b1, W2);
      vt[18] = mk(1'b0, 4'b0100, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, A5,            8'h10, 1'b1, W2);
      vt[19] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, A5,            8'h10, 1'b1, W2);
      vt[20] = mk(1'b0, 4'b1000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, A5,            8'h30, 1'b0, W3);
      vt[21] = mk(1'b0, 4'b0001, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, A5,            8'h30, 1'b0, W3);
      vt[22] = mk(1'b0, 4'b0001, 1'b1, 1'b0, 32'h12345678,  1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 32'h12345678,  8'h30, 1'b0, W3);
      vt[23] = mk(1'b0, 4'b0001, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 32'h12345678,  8'h04, 1'b0, W0);
      vt[24] = mk(1'b0, 4'b0001, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 32'h12345678,  8'h04, 1'b0, W0);
      vt[25] = mk(1'b0, 4'b0001, 1'b1, 1'b1, 32'h0BADF00D,  1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 32'h0BADF00D,  8'h04, 1'b0, W0);
      vt[26] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0BADF00D,  8'h04, 1'b0, W0);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         reset       = vt[i].rst;
         bus.req     = vt[i].req;
         bus.pready  = vt[i].pready;
         bus.pslverr = vt[i].pslverr;
         bus.prdata  = vt[i].prdata;
         @(posedge clk); #1;
         chk($sformatf("v%0d.psel", i),    32'(bus.psel),    32'(vt[i].e_psel));
         chk($sformatf("v%0d.penable", i), 32'(bus.penable), 32'(vt[i].e_pen));
         chk($sformatf("v%0d.gnt", i),     32'(bus.gnt),     32'(vt[i].e_gnt));
         chk($sformatf("v%0d.done", i),    32'(bus.done),    32'(vt[i].e_done));
         chk($sformatf("v%0d.err", i),     32'(bus.err),     32'(vt[i].e_err));
         chk($sformatf("v%0d.rdata", i),   bus.rdata,        vt[i].e_rdata);
         chk($sformatf("v%0d.paddr", i),   32'(bus.paddr),   32'(vt[i].e_paddr));
         chk($sformatf("v%0d.pwrite", i),  32'(bus.pwrite),  32'(vt[i].e_pwrite));
         chk($sformatf("v%0d.pwdata", i),  bus.pwdata,       vt[i].e_pwdata);
      end

      // All four requesting from reset: order 0,1,2,3, zero wait states each.
      @(negedge clk);
      reset = 1'b1; bus.req = 4'b0000; bus.pready = 1'b1; bus.pslverr = 1'b0; bus.prdata = RD;
      @(negedge clk);
      reset = 1'b0; bus.req = 4'b1111;
      for (int n = 0; n < 4; n++) begin
         wait_done(20, d, g, acc);
         chk($sformatf("rr%0d.gnt", n),  32'(g),    32'(4'b0001 << n));
         chk($sformatf("rr%0d.done", n), 32'(d),    32'(4'b0001 << n));
         chk($sformatf("rr%0d.acc", n),  32'(acc),  32'd1);
         chk($sformatf("rr%0d.psel", n), 32'(bus.psel), 32'd0);
         @(negedge clk);
         bus.req = bus.req & ~d;
      end
      // Pointer wrapped to 0: 1 beats 3.
      bus.req = 4'b1010;
      wait_done(20, d, g, acc);
      chk("wrap.first", 32'(d), 32'(4'b0010));
      @(negedge clk);
      bus.req = bus.req & ~d;
      wait_done(20, d, g, acc);
      chk("wrap.second", 32'(d), 32'(4'b1000));
      @(negedge clk);
      bus.req = bus.req & ~d;

      // Reset mid-ACCESS with the pointer at 2.
      bus.req = 4'b0010;
      wait_done(20, d, g, acc);
      chk("pre_rst.done", 32'(d), 32'(4'b0010));
      @(negedge clk);
      bus.req = 4'b0100; bus.pready = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (bus.penable) begin
            seen = 1'b1;
            break;
         end
      end
      chk("pre_rst.access", 32'(seen), 32'd1);
      @(negedge clk);
      reset = 1'b1; bus.req = 4'b0000; bus.pready = 1'b1;
      @(posedge clk); #1;
      chk("rst.psel",    32'(bus.psel),    32'd0);
      chk("rst.penable", 32'(bus.penable), 32'd0);
      chk("rst.gnt",     32'(bus.gnt),     32'd0);
      chk("rst.done",    32'(bus.done),    32'd0);
      chk("rst.rdata",   bus.rdata,        32'd0);
      chk("rst.paddr",   32'(bus.paddr),   32'd0);
      @(negedge clk);
      reset = 1'b0; bus.req = 4'b1001;
      wait_done(20, d, g, acc);
      chk("post_rst.gnt",  32'(g), 32'(4'b0001));
      chk("post_rst.done", 32'(d), 32'(4'b0001));
      @(negedge clk);
      bus.req = bus.req & ~d;
      wait_done(20, d, g, acc);
      chk("post_rst.next", 32'(d), 32'(4'b1000));
      @(negedge clk);
      bus.req = bus.req & ~d;

      // Slave never ready.
      bus.req = 4'b0001; bus.pready = 1'b0; bus.prdata = 32'hFFFF0000;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
      wait_done(40, d, g, acc);
      chk("tmo.done",    32'(d),           32'(4'b0001));
      chk("tmo.acc",     32'(acc),         32'(TIMEOUT_CYC));
      chk("tmo.err",     32'(bus.err),     32'd1);
      chk("tmo.psel",    32'(bus.psel),    32'd0);
      chk("tmo.penable", 32'(bus.penable), 32'd0);
      chk("tmo.rdata",   bus.rdata,        RD);
      @(negedge clk);
      bus.req = 4'b0000;
`else
      hi_cnt = 0;
      d_cnt  = 0;
      for (int c = 0; c < 120; c++) begin
         @(posedge clk); #1;
         if (bus.psel) hi_cnt++;
         if (bus.done != 4'b0000) d_cnt++;
      end
      chk("stall.psel_cycles", 32'(hi_cnt), 32'd120);
      chk("stall.no_done",     32'(d_cnt),  32'd0);
      chk("stall.penable",     32'(bus.penable), 32'd1);
      @(negedge clk);
      bus.pready = 1'b1;
      wait_done(5, d, g, acc);
      chk("stall.release", 32'(d), 32'(4'b0001));
      @(negedge clk);
      bus.req = 4'b0000;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
